uart_cmd_dispatch: RTL and testbench

UART_CMD_DISPATCH -- requirements
Module: uart_cmd_dispatch

---
 rtl/uart_cmd_dispatch_if.sv | 12 +
 rtl/uart_cmd_dispatch.sv | 174 +++++++++++++++++
 tb/tb_uart_cmd_dispatch.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_dispatch_if.sv
// Byte-stream handshake bundle for the command dispatcher:
// UART receive strobe toward the block, response byte back out.
interface uart_cmd_dispatch_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (output rx_data, output rx_valid, input tx_data, input tx_valid, output tx_ready);
   modport slave  (input rx_data, input rx_valid, output tx_data, output tx_valid, input tx_ready);
endinterface

// File: rtl/uart_cmd_dispatch.sv
// Parses 14-byte UART command frames (0x55 .. chk 0xAA), applies PWM channel
// configuration or enable changes, and answers each complete frame with ACK/NAK.
module uart_cmd_dispatch #(
   parameter int NUM_CH      = 4,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   uart_cmd_dispatch_if.slave    uart_if,
   output logic                  cfg_wr,
   output logic [7:0]            cfg_ch,
   output logic [7:0]            cfg_duty,
   output logic [15:0]           cfg_pulse_dessert,
   output logic [7:0]            cfg_pulse_num,
   output logic [31:0]           cfg_pat,
   output logic [NUM_CH-1:0]     ch_enable,
   output logic [15:0]           frame_err_cnt
);

   localparam int            TW       = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      PAYLOAD = 3'd1,
      CHK     = 3'd2,
      TAIL    = 3'd3,
      EXEC    = 3'd4,
      RESP    = 3'd5
   } state_t;

   state_t            state_q;
   logic [3:0]        idx_q;
   logic [TW-1:0]     tmo_q;
   logic [10:0][7:0]  pl_q;        // func, ch, ctrl_sta, duty, dH, dL, pulse_num, pat[31:0]
   logic [7:0]        chk_acc_q;
   logic [7:0]        chk_rx_q;
   logic              tail_ok_q;

   logic              cfg_wr_q;
   logic [7:0]        cfg_ch_q;
   logic [7:0]        cfg_duty_q;
   logic [15:0]       cfg_dessert_q;
   logic [7:0]        cfg_pnum_q;
   logic [31:0]       cfg_pat_q;
   logic [NUM_CH-1:0] ch_enable_q;
   logic [7:0]        tx_data_q;
   logic              tx_valid_q;
   logic [15:0]       err_cnt_q;

   logic              func_ok_s;
   logic              ch_ok_s;
   logic              ack_s;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Frame acceptance decision, evaluated from the latched frame during EXEC
   always_comb begin
      func_ok_s = (pl_q[0] == 8'h01) || (pl_q[0] == 8'h02);
      ch_ok_s   = (pl_q[1] >= 8'd1) && (pl_q[1] <= 8'(NUM_CH));
      ack_s     = tail_ok_q && (chk_acc_q == chk_rx_q) && func_ok_s && ch_ok_s;
   end

   // Frame receive / execute / respond state machine with registered outputs
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q       <= IDLE;
         idx_q         <= 4'd0;
         tmo_q         <= '0;
         pl_q          <= '0;
         chk_acc_q     <= 8'd0;
         chk_rx_q      <= 8'd0;
         tail_ok_q     <= 1'b0;
         cfg_wr_q      <= 1'b0;
         cfg_ch_q      <= 8'd0;
         cfg_duty_q    <= 8'd0;
         cfg_dessert_q <= 16'd0;
         cfg_pnum_q    <= 8'd0;
         cfg_pat_q     <= 32'd0;
         ch_enable_q   <= '0;
         tx_data_q     <= 8'd0;
         tx_valid_q    <= 1'b0;
         err_cnt_q     <= 16'd0;
      end else begin
         cfg_wr_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (uart_if.rx_valid && (uart_if.rx_data == 8'h55)) begin
                  state_q   <= PAYLOAD;
                  idx_q     <= 4'd0;
                  tmo_q     <= '0;
                  chk_acc_q <= 8'd0;
               end
            end
            PAYLOAD, CHK, TAIL: begin
               // A byte in the expiry cycle still wins over the timeout
               if (uart_if.rx_valid) begin
                  tmo_q <= '0;
                  case (state_q)
                     PAYLOAD: begin
                        pl_q[idx_q] <= uart_if.rx_data;
                        chk_acc_q   <= chk_acc_q ^ uart_if.rx_data;
                        if (idx_q == 4'd10) begin
                           state_q <= CHK;
                        end else begin
                           idx_q <= idx_q + 4'd1;
                        end
                     end
                     CHK: begin
                        chk_rx_q <= uart_if.rx_data;
                        state_q  <= TAIL;
                     end
                     default: begin
                        tail_ok_q <= (uart_if.rx_data == 8'hAA);
                        state_q   <= EXEC;
                     end
                  endcase
               end else if (tmo_q == TMO_LAST) begin
                  state_q   <= IDLE;
                  tmo_q     <= '0;
                  idx_q     <= 4'd0;
                  err_cnt_q <= sat_inc(err_cnt_q);
               end else begin
                  tmo_q <= tmo_q + TW'(1);
               end
            end
            EXEC: begin
               state_q    <= RESP;
               tx_valid_q <= 1'b1;
               tx_data_q  <= ack_s ? 8'h06 : 8'h15;
               if (!ack_s) begin
                  err_cnt_q <= sat_inc(err_cnt_q);
               end else if (pl_q[0] == 8'h01) begin
                  cfg_wr_q      <= 1'b1;
                  cfg_ch_q      <= pl_q[1];
                  cfg_duty_q    <= pl_q[3];
                  cfg_dessert_q <= {pl_q[4], pl_q[5]};
                  cfg_pnum_q    <= pl_q[6];
                  cfg_pat_q     <= {pl_q[7], pl_q[8], pl_q[9], pl_q[10]};
               end else begin
                  for (int i = 0; i < NUM_CH; i++) begin
                     if (pl_q[1] == 8'(i + 1)) begin
                        ch_enable_q[i] <= pl_q[2][0];
                     end
                  end
               end
            end
            RESP: begin
               if (uart_if.tx_ready) begin
                  tx_valid_q <= 1'b0;
                  state_q    <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign cfg_wr            = cfg_wr_q;
   assign cfg_ch            = cfg_ch_q;
   assign cfg_duty          = cfg_duty_q;
   assign cfg_pulse_dessert = cfg_dessert_q;
   assign cfg_pulse_num     = cfg_pnum_q;
   assign cfg_pat           = cfg_pat_q;
   assign ch_enable         = ch_enable_q;
   assign frame_err_cnt     = err_cnt_q;
   assign uart_if.tx_data   = tx_data_q;
   assign uart_if.tx_valid  = tx_valid_q;

endmodule

// File: tb/tb_uart_cmd_dispatch.sv
// Directed bench for uart_cmd_dispatch: a frame vector table plus hand-written
// sequences for latency, timeout boundary, backpressure and mid-frame reset.
module tb_uart_cmd_dispatch;
   localparam int NCH = 4;
   localparam int TMO = 64;

   logic        clk;
   logic        rst_n;
   logic        cfg_wr;
   logic [7:0]  cfg_ch;
   logic [7:0]  cfg_duty;
   logic [15:0] cfg_pulse_dessert;
   logic [7:0]  cfg_pulse_num;
   logic [31:0] cfg_pat;
   logic [NCH-1:0] ch_enable;
   logic [15:0] frame_err_cnt;

   uart_cmd_dispatch_if uif();

   uart_cmd_dispatch #(.NUM_CH(NCH), .TIMEOUT_CYC(TMO)) dut (
      .sys_clk           (clk),
      .sys_rst_n         (rst_n),
      .uart_if           (uif.slave),
      .cfg_wr            (cfg_wr),
      .cfg_ch            (cfg_ch),
      .cfg_duty          (cfg_duty),
      .cfg_pulse_dessert (cfg_pulse_dessert),
      .cfg_pulse_num     (cfg_pulse_num),
      .cfg_pat           (cfg_pat),
      .ch_enable         (ch_enable),
      .frame_err_cnt     (frame_err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  func, ch, ctrl, duty, dh, dl, pn;
      logic [31:0] pat;
      logic [7:0]  chk_flip, tail;
      logic        exp_ack, exp_wr;
      logic [3:0]  exp_en;
      logic [15:0] exp_err;
   } vec_t;

   int n_tests = 0;
   int n_fail  = 0;
   int wr_cnt  = 0;
   int tx_cnt  = 0;
   logic [7:0] tx_last = 8'h00;

   logic [7:0]  m_ch, m_duty, m_pn;
   logic [15:0] m_des;
   logic [31:0] m_pat;

   // Count write pulses and completed response handshakes away from the clock edge
   always @(negedge clk) begin
      if (cfg_wr) wr_cnt++;
      if (uif.tx_valid && uif.tx_ready) begin
         tx_cnt++;
         tx_last = uif.tx_data;
      end
   end

   function automatic vec_t mk(input logic [7:0] func, ch, ctrl, duty, dh, dl, pn,
                               input logic [31:0] pat, input logic [7:0] flip, tail,
                               input logic ack, wr, input logic [3:0] en, input logic [15:0] err);
      vec_t v;
      v.func = func; v.ch = ch; v.ctrl = ctrl; v.duty = duty; v.dh = dh; v.dl = dl;
      v.pn = pn; v.pat = pat; v.chk_flip = flip; v.tail = tail;
      v.exp_ack = ack; v.exp_wr = wr; v.exp_en = en; v.exp_err = err;
      return v;
   endfunction

   function automatic logic [7:0] calc_chk(input vec_t v);
      return v.func ^ v.ch ^ v.ctrl ^ v.duty ^ v.dh ^ v.dl ^ v.pn ^
             v.pat[31:24] ^ v.pat[23:16] ^ v.pat[15:8] ^ v.pat[7:0];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send_byte(input logic [7:0] b);
      uif.rx_valid = 1'b1;
      uif.rx_data  = b;
      tick();
      uif.rx_valid = 1'b0;
   endtask

   task automatic send_range(input vec_t v, input int first, input int last, input int split, input int gap);
      logic [7:0] b [14];
      b[0] = 8'h55;  b[1] = v.func; b[2] = v.ch;  b[3] = v.ctrl; b[4] = v.duty;
      b[5] = v.dh;   b[6] = v.dl;   b[7] = v.pn;
      b[8] = v.pat[31:24]; b[9] = v.pat[23:16]; b[10] = v.pat[15:8]; b[11] = v.pat[7:0];
      b[12] = calc_chk(v) ^ v.chk_flip;
      b[13] = v.tail;
      for (int i = first; i <= last; i++) begin
         if (split != 0 && i == split) idle(gap);
         send_byte(b[i]);
      end
   endtask

   task automatic model_write(input vec_t v);
      m_ch = v.ch; m_duty = v.duty; m_des = {v.dh, v.dl}; m_pn = v.pn; m_pat = v.pat;
   endtask

   task automatic check_cfg(input string tag);
      chk({tag, "_cfg_ch"}, 32'(cfg_ch), 32'(m_ch));
      chk({tag, "_cfg_duty"}, 32'(cfg_duty), 32'(m_duty));
      chk({tag, "_cfg_dessert"}, 32'(cfg_pulse_dessert), 32'(m_des));
      chk({tag, "_cfg_pnum"}, 32'(cfg_pulse_num), 32'(m_pn));
      chk({tag, "_cfg_pat"}, cfg_pat, m_pat);
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int w0, t0;
      w0 = wr_cnt;
      t0 = tx_cnt;
      send_range(v, 0, 13, 0, 0);
      idle(6);
      chk({tag, "_resp_cnt"}, 32'(tx_cnt - t0), 32'd1);
      chk({tag, "_resp_code"}, 32'(tx_last), v.exp_ack ? 32'h06 : 32'h15);
      chk({tag, "_wr_cnt"}, 32'(wr_cnt - w0), 32'(v.exp_wr));
      chk({tag, "_en"}, 32'(ch_enable), 32'(v.exp_en));
      chk({tag, "_err"}, 32'(frame_err_cnt), 32'(v.exp_err));
      if (v.exp_wr) model_write(v);
      check_cfg(tag);
   endtask

   vec_t vecs[13];
   vec_t v;
   int   w0, t0, bad;
   logic [7:0] ign [14];

   initial begin
      //           func   ch     ctrl   duty   dH     dL     pnum   pat           flip   tail   ack  wr  en       err
      vecs[0]  = mk(8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h01, 8'h00, 32'h00000001, 8'h00, 8'hAA, 1'b1, 1'b1, 4'b0000, 16'd0);
      vecs[1]  = mk(8'h02, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 32'h00000000, 8'h00, 8'hAA, 1'b1, 1'b0, 4'b0100, 16'd0);
      vecs[2]  = mk(8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 32'h00000000, 8'h00, 8'hAA, 1'b1, 1'b0, 4'b0000, 16'd0);
      vecs[3]  = mk(8'h01, 8'h02, 8'h00, 8'h80, 8'h12, 8'h34, 8'h05, 32'hDEADBEEF, 8'h01, 8'hAA, 1'b0, 1'b0, 4'b0000, 16'd1);
      vecs[4]  = mk(8'h01, 8'h05, 8'h00, 8'h80, 8'h12, 8'h34, 8'h05, 32'hDEADBEEF, 8'h00, 8'hAA, 1'b0, 1'b0, 4'b0000, 16'd2);
      vecs[5]  = mk(8'h02, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 32'h00000000, 8'h00, 8'hAA, 1'b0, 1'b0, 4'b0000, 16'd3);
      vecs[6]  = mk(8'h03, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 32'h00000000, 8'h00, 8'hAA, 1'b0, 1'b0, 4'b0000, 16'd4);
      vecs[7]  = mk(8'h01, 8'h01, 8'h00, 8'h44, 8'h00, 8'h00, 8'h00, 32'h00000000, 8'h00, 8'hAB, 1'b0, 1'b0, 4'b0000, 16'd5);
      vecs[8]  = mk(8'h01, 8'h04, 8'h00, 8'h80, 8'h12, 8'h34, 8'h05, 32'hDEADBEEF, 8'h00, 8'hAA, 1'b1, 1'b1, 4'b0000, 16'd5);
      vecs[9]  = mk(8'h02, 8'h04, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 32'h00000000, 8'h00, 8'hAA, 1'b1, 1'b0, 4'b1000, 16'd5);
      vecs[10] = mk(8'h02, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 32'h00000000, 8'h00, 8'hAA, 1'b1, 1'b0, 4'b1001, 16'd5);
      vecs[11] = mk(8'h02, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 32'h00000000, 8'h00, 8'hAA, 1'b1, 1'b0, 4'b1011, 16'd5);
      vecs[12] = mk(8'h01, 8'h04, 8'h00, 8'h55, 8'h55, 8'h55, 8'h55, 32'h55555555, 8'h00, 8'hAA, 1'b1, 1'b1, 4'b1011, 16'd5);

      m_ch = 8'h00; m_duty = 8'h00; m_des = 16'h0000; m_pn = 8'h00; m_pat = 32'h0;
      uif.rx_valid = 1'b0;
      uif.rx_data  = 8'h00;
      uif.tx_ready = 1'b1;
      rst_n = 1'b0;
      idle(3);
      chk("rst_tx_valid", 32'(uif.tx_valid), 32'd0);
      chk("rst_tx_data", 32'(uif.tx_data), 32'd0);
      chk("rst_err", 32'(frame_err_cnt), 32'd0);
      chk("rst_en", 32'(ch_enable), 32'd0);
      check_cfg("rst");
      rst_n = 1'b1;
      tick();

      // Non-header bytes in IDLE are dropped silently
      t0 = tx_cnt;
      send_byte(8'h00); send_byte(8'hAA); send_byte(8'h13);
      idle(4);
      chk("idle_garbage_resp", 32'(tx_cnt - t0), 32'd0);

      for (int i = 0; i < 13; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // cfg_wr arrives one cycle after EXEC, lasts one cycle, alongside ACK
      v = mk(8'h01, 8'h03, 8'h00, 8'h10, 8'hAB, 8'hCD, 8'h7F, 32'h01020304, 8'h00, 8'hAA, 1'b1, 1'b1, 4'b1011, 16'd5);
      send_range(v, 0, 13, 0, 0);
      chk("lat_exec_wr", 32'(cfg_wr), 32'd0);
      chk("lat_exec_txv", 32'(uif.tx_valid), 32'd0);
      tick();
      chk("lat_resp_wr", 32'(cfg_wr), 32'd1);
      chk("lat_resp_txv", 32'(uif.tx_valid), 32'd1);
      chk("lat_resp_txd", 32'(uif.tx_data), 32'h06);
      model_write(v);
      check_cfg("lat");
      tick();
      chk("lat_after_wr", 32'(cfg_wr), 32'd0);
      chk("lat_after_txv", 32'(uif.tx_valid), 32'd0);
      idle(2);

      // Gap of TMO-1 idle cycles: byte lands on the expiry cycle, frame survives
      v = mk(8'h02, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 32'h0, 8'h00, 8'hAA, 1'b1, 1'b0, 4'b1001, 16'd5);
      t0 = tx_cnt;
      send_range(v, 0, 13, 6, TMO - 1);
      idle(6);
      chk("tmo_edge_resp", 32'(tx_cnt - t0), 32'd1);
      chk("tmo_edge_code", 32'(tx_last), 32'h06);
      chk("tmo_edge_en", 32'(ch_enable), 32'b1001);
      chk("tmo_edge_err", 32'(frame_err_cnt), 32'd5);

      // Gap of TMO idle cycles: frame dropped, rest of bytes fall into IDLE
      v = mk(8'h02, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 32'h0, 8'h00, 8'hAA, 1'b0, 1'b0, 4'b1001, 16'd6);
      t0 = tx_cnt;
      send_range(v, 0, 13, 6, TMO);
      idle(6);
      chk("tmo_resp", 32'(tx_cnt - t0), 32'd0);
      chk("tmo_err", 32'(frame_err_cnt), 32'd6);
      chk("tmo_en", 32'(ch_enable), 32'b1001);
      run_vec(mk(8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 32'h0, 8'h00, 8'hAA,
                 1'b1, 1'b0, 4'b1000, 16'd6), "tmo_recover");

      // Backpressure: response held, bytes during EXEC/RESP (incl. a full frame) ignored
      uif.tx_ready = 1'b0;
      v = mk(8'h01, 8'h02, 8'h00, 8'h22, 8'h00, 8'h10, 8'h03, 32'hCAFE0001, 8'h00, 8'hAA, 1'b1, 1'b1, 4'b1000, 16'd6);
      ign[0] = 8'h55; ign[1] = 8'h02; ign[2] = 8'h03; ign[3] = 8'h01;
      for (int k = 4; k < 12; k++) ign[k] = 8'h00;
      ign[12] = 8'h00; ign[13] = 8'hAA;
      w0 = wr_cnt;
      t0 = tx_cnt;
      bad = 0;
      send_range(v, 0, 13, 0, 0);
      for (int i = 0; i < 100; i++) begin
         uif.rx_valid = (i < 14);
         uif.rx_data  = (i < 14) ? ign[i] : 8'h00;
         tick();
         if (!(uif.tx_valid === 1'b1 && uif.tx_data === 8'h06)) bad++;
      end
      uif.rx_valid = 1'b0;
      chk("bp_hold_bad_cycles", 32'(bad), 32'd0);
      chk("bp_wr_cnt", 32'(wr_cnt - w0), 32'd1);
      chk("bp_en", 32'(ch_enable), 32'b1000);
      chk("bp_no_handshake", 32'(tx_cnt - t0), 32'd0);
      model_write(v);
      check_cfg("bp");
      uif.tx_ready = 1'b1;
      idle(3);
      chk("bp_release_cnt", 32'(tx_cnt - t0), 32'd1);
      chk("bp_release_txv", 32'(uif.tx_valid), 32'd0);
      run_vec(mk(8'h02, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 32'h0, 8'h00, 8'hAA,
                 1'b1, 1'b0, 4'b0000, 16'd6), "bp_after");

      // Reset after byte 7, then the frame tail must be treated as IDLE input
      v = vecs[0];
      send_range(v, 0, 6, 0, 0);
      rst_n = 1'b0;
      #1;
      chk("mrst_wr", 32'(cfg_wr), 32'd0);
      chk("mrst_txv", 32'(uif.tx_valid), 32'd0);
      chk("mrst_txd", 32'(uif.tx_data), 32'd0);
      chk("mrst_en", 32'(ch_enable), 32'd0);
      chk("mrst_err", 32'(frame_err_cnt), 32'd0);
      m_ch = 8'h00; m_duty = 8'h00; m_des = 16'h0000; m_pn = 8'h00; m_pat = 32'h0;
      check_cfg("mrst");
      idle(2);
      rst_n = 1'b1;
      tick();
      t0 = tx_cnt;
      send_range(v, 7, 13, 0, 0);
      idle(4);
      chk("mrst_tail_resp", 32'(tx_cnt - t0), 32'd0);
      run_vec(vecs[0], "mrst_after");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
